// File: rtl/servo_pkg.sv
// servo_pkg: shared derivations and arithmetic helpers
// for the multi-channel servo PWM bank.
package servo_pkg;

  function automatic int ticks_per_us(input int hz);
    return hz / 1_000_000;
  endfunction

  function automatic int center_us(input int lo, input int hi);
    return (lo + hi) / 2;
  endfunction

  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] clamp(
    input logic [31:0] v,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    logic [31:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

  // Move cur toward tgt by at most slew; slew 0 means jump.
  function automatic logic [31:0] step_toward(
    input logic [31:0] cur,
    input logic [31:0] tgt,
    input logic [31:0] slew
  );
    logic [31:0] r;
    r = tgt;
    if (slew != 0) begin
      if (tgt > cur && (tgt - cur) > slew)
        r = cur + slew;
      else if (cur > tgt && (cur - tgt) > slew)
        r = cur - slew;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_bank_if.sv
// servo_bank_if: valid/ready command port carrying
// a channel index and a pulse width in microseconds.
interface servo_bank_if #(
  parameter int CH_W  = 2,
  parameter int POS_W = 15
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_ch;
  logic [POS_W-1:0] cmd_us;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_ch, cmd_us,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_us,
    output cmd_ready, cmd_err
  );
endinterface

// File: rtl/servo_channel.sv
// servo_channel: target/current width registers, slew
// update at frame boundaries and registered PWM compare.
module servo_channel
  import servo_pkg::*;
#(
  parameter int POS_W  = 15,
  parameter int CENTER = 1500,
  parameter int SLEW   = 10
) (
  input  logic             CLK25MHZ,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [POS_W-1:0] us_cnt,
  input  logic             en,
  input  logic             we,
  input  logic [POS_W-1:0] wdata,
  output logic             servo_out,
  output logic             busy
);

  logic [POS_W-1:0] tgt;
  logic [POS_W-1:0] cur;
  logic [POS_W-1:0] cur_nxt;
  logic             en_q;
  logic             en_nxt;

  // Values the new frame will use, so the compare on the
  // boundary cycle already sees the updated width/enable.
  always_comb begin
    cur_nxt = cur;
    en_nxt  = en_q;
    if (frame_start) begin
      cur_nxt = POS_W'(step_toward(32'(cur), 32'(tgt),
                                   32'(SLEW)));
      en_nxt  = en;
    end
  end

  // State, output and busy registers.
  always_ff @(posedge CLK25MHZ or posedge reset) begin
    if (reset) begin
      tgt       <= POS_W'(CENTER);
      cur       <= POS_W'(CENTER);
      en_q      <= 1'b0;
      servo_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (we) tgt <= wdata;
      cur       <= cur_nxt;
      en_q      <= en_nxt;
      servo_out <= en_nxt && (us_cnt < cur_nxt);
      busy      <= (cur != tgt);
    end
  end

endmodule

// File: rtl/servo_bank.sv
// servo_bank: NUM_CH hobby-servo PWM outputs sharing one
// frame timer, with clamped, slew-limited width commands.
module servo_bank
  import servo_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int FRAME_US    = 20000,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int SLEW_US     = 10,
  parameter int POS_W       = 15
) (
  input  logic              CLK25MHZ,
  input  logic              reset,
  servo_bank_if.slave       cmd,
  input  logic [NUM_CH-1:0] enable,
  output logic [NUM_CH-1:0] servo_out,
  output logic              frame_start,
  output logic [NUM_CH-1:0] busy
);

  localparam int TICKS  = ticks_per_us(CLK_FREQ_HZ);
  localparam int CENTER = center_us(MIN_US, MAX_US);
  localparam int PS_W   = bits_for(TICKS);

  logic [PS_W-1:0]  ps;
  logic [POS_W-1:0] us_cnt;
  logic             us_tick;
  logic             wrap;
  logic             accept;
  logic             bad_ch;
  logic [POS_W-1:0] cmd_clamped;

  // Timer terminal counts and command decode.
  always_comb begin
    us_tick = (ps == PS_W'(TICKS - 1));
    wrap    = us_tick &&
              (us_cnt == POS_W'(FRAME_US - 1));
    accept  = cmd.cmd_valid && cmd.cmd_ready;
    bad_ch  = (int'(cmd.cmd_ch) >= NUM_CH);
    cmd_clamped = POS_W'(clamp(32'(cmd.cmd_us),
                               32'(MIN_US),
                               32'(MAX_US)));
  end

  // Microsecond prescaler and frame counter.
  always_ff @(posedge CLK25MHZ or posedge reset) begin
    if (reset) begin
      ps     <= '0;
      us_cnt <= '0;
    end else begin
      ps <= us_tick ? '0 : ps + PS_W'(1);
      if (us_tick)
        us_cnt <= wrap ? '0 : us_cnt + POS_W'(1);
    end
  end

  // Boundary pulse; ready drops on the boundary cycle
  // because the channels read tgt for the slew update.
  always_ff @(posedge CLK25MHZ or posedge reset) begin
    if (reset) begin
      frame_start   <= 1'b0;
      cmd.cmd_ready <= 1'b0;
      cmd.cmd_err   <= 1'b0;
    end else begin
      frame_start   <= wrap;
      cmd.cmd_ready <= !wrap;
      cmd.cmd_err   <= accept && bad_ch;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we;
    assign we = accept && !bad_ch &&
                (int'(cmd.cmd_ch) == i);

    servo_channel #(
      .POS_W  (POS_W),
      .CENTER (CENTER),
      .SLEW   (SLEW_US)
    ) u_ch (
      .CLK25MHZ    (CLK25MHZ),
      .reset       (reset),
      .frame_start (frame_start),
      .us_cnt      (us_cnt),
      .en          (enable[i]),
      .we          (we),
      .wdata       (cmd_clamped),
      .servo_out   (servo_out[i]),
      .busy        (busy[i])
    );
  end

endmodule

// File: tb/tb_servo_bank.sv
// tb_servo_bank: directed checks of frame timing, slew,
// clamping, command errors, boundary collision, enable, reset.
module tb_servo_bank;
  import servo_pkg::*;

  localparam int NUM_CH = 5;
  localparam int CLK_HZ = 2_000_000;
  localparam int FRAME  = 200;
  localparam int MINU   = 50;
  localparam int MAXU   = 150;
  localparam int SLEW   = 10;
  localparam int POS_W  = 15;
  localparam int CH_W   = bits_for(NUM_CH);
  localparam int TPU    = 2;
  localparam int FCYC   = FRAME * TPU;

  logic CLK25MHZ = 1'b0;
  logic reset = 1'b0;
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] servo_out;
  logic [NUM_CH-1:0] busy;
  logic frame_start;

  servo_bank_if #(.CH_W(CH_W), .POS_W(POS_W)) cif ();

  servo_bank #(
    .NUM_CH      (NUM_CH),
    .CLK_FREQ_HZ (CLK_HZ),
    .FRAME_US    (FRAME),
    .MIN_US      (MINU),
    .MAX_US      (MAXU),
    .SLEW_US     (SLEW),
    .POS_W       (POS_W)
  ) dut (
    .CLK25MHZ    (CLK25MHZ),
    .reset       (reset),
    .cmd         (cif.slave),
    .enable      (enable),
    .servo_out   (servo_out),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 CLK25MHZ = ~CLK25MHZ;

  int checks = 0;
  int failures = 0;
  int model [NUM_CH];

  typedef struct {
    logic [CH_W-1:0]  ch;
    logic [POS_W-1:0] us;
    int               exp_us;
    bit               err;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK25MHZ);
    #1;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame_start && n < 2000) begin
      step();
      n++;
    end
    if (!frame_start) begin
      checks++;
      failures++;
      $display("FAIL wait_frame: got timeout expected frame_start");
    end
  endtask

  task automatic measure(input int chg_step,
                         input logic [NUM_CH-1:0] chg_en,
                         output int w [NUM_CH],
                         output logic [NUM_CH-1:0] b1,
                         output logic [NUM_CH-1:0] b2,
                         output int fs_at);
    for (int c = 0; c < NUM_CH; c++) w[c] = 0;
    b1 = '0;
    b2 = '0;
    fs_at = -1;
    for (int s = 1; s <= FCYC; s++) begin
      step();
      if (s == chg_step) enable = chg_en;
      for (int c = 0; c < NUM_CH; c++)
        if (servo_out[c]) w[c]++;
      if (s == 1) b1 = busy;
      if (s == 2) b2 = busy;
      if (frame_start && fs_at < 0) fs_at = s;
    end
  endtask

  task automatic check_frame(input string tag);
    int w [NUM_CH];
    logic [NUM_CH-1:0] b1, b2;
    int fs;
    measure(-1, enable, w, b1, b2, fs);
    check({tag, "_flen"}, fs, FCYC);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("%s_w%0d", tag, c), w[c],
            model[c] * TPU);
  endtask

  task automatic send_cmd(input logic [CH_W-1:0] ch,
                          input logic [POS_W-1:0] us);
    int n = 0;
    cif.cmd_ch = ch;
    cif.cmd_us = us;
    cif.cmd_valid = 1'b1;
    while (!cif.cmd_ready && n < 10) begin
      step();
      n++;
    end
    if (!cif.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL send_cmd: got timeout expected ready");
    end
    step();
    cif.cmd_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    int n = 0;
    int hi = 0;
    int rdy1 = 0;
    reset = 1'b1;
    #1;
    check({tag, "_out"}, int'(servo_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_rdy"}, int'(cif.cmd_ready), 0);
    check({tag, "_err"}, int'(cif.cmd_err), 0);
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) model[c] = 100;
    while (!frame_start && n < 1000) begin
      step();
      n++;
      if (n == 1) rdy1 = int'(cif.cmd_ready);
      hi = hi | int'(servo_out);
    end
    check({tag, "_first_fs"}, n, FCYC);
    check({tag, "_dark"}, hi, 0);
    check({tag, "_rdy1"}, rdy1, 1);
    check_frame({tag, "_f1"});
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w [NUM_CH];
    logic [NUM_CH-1:0] b1, b2;
    int fs, cnt, prev, n;

    tbl[0] = '{3'd1, 15'd20,    50,  1'b0};
    tbl[1] = '{3'd2, 15'd30000, 150, 1'b0};
    tbl[2] = '{3'd3, 15'd120,   120, 1'b0};
    tbl[3] = '{3'd5, 15'd60,    0,   1'b1};
    tbl[4] = '{3'd4, 15'd150,   150, 1'b0};
    tbl[5] = '{3'd0, 15'd49,    50,  1'b0};
    tbl[6] = '{3'd7, 15'd0,     0,   1'b1};
    tbl[7] = '{3'd3, 15'd151,   150, 1'b0};
    tbl[8] = '{3'd1, 15'd50,    50,  1'b0};

    enable = '1;
    cif.cmd_valid = 1'b0;
    cif.cmd_ch = '0;
    cif.cmd_us = '0;
    step();
    do_reset("rst0");

    // slew ramp ch0: 100 -> 150 at 10 us per frame
    send_cmd(3'd0, 15'd150);
    check("ramp_err", int'(cif.cmd_err), 0);
    step();
    check("ramp_busy0", int'(busy[0]), 1);
    for (int f = 1; f <= 5; f++) begin
      wait_frame();
      measure(-1, enable, w, b1, b2, fs);
      check($sformatf("ramp%0d_w0", f), w[0],
            (100 + 10 * f) * TPU);
      check($sformatf("ramp%0d_w1", f), w[1], 100 * TPU);
      check($sformatf("ramp%0d_b1", f), int'(b1[0]), 1);
      check($sformatf("ramp%0d_b2", f), int'(b2[0]),
            (f < 5) ? 1 : 0);
    end
    model[0] = 150;

    for (int k = 0; k < 9; k++) begin
      prev = tbl[k].err ? 0 : model[tbl[k].ch];
      send_cmd(tbl[k].ch, tbl[k].us);
      check($sformatf("t%0d_err", k), int'(cif.cmd_err),
            int'(tbl[k].err));
      step();
      check($sformatf("t%0d_err_clr", k),
            int'(cif.cmd_err), 0);
      if (tbl[k].err) begin
        check($sformatf("t%0d_busy", k), int'(busy), 0);
      end else begin
        check($sformatf("t%0d_busy", k),
              int'(busy[tbl[k].ch]),
              (tbl[k].exp_us != prev) ? 1 : 0);
        model[tbl[k].ch] = tbl[k].exp_us;
      end
      n = 0;
      while (busy != '0 && n < 8000) begin
        step();
        n++;
      end
      check($sformatf("t%0d_settle", k), int'(busy), 0);
      wait_frame();
      check_frame($sformatf("t%0d", k));
    end

    // command held across a frame boundary
    wait_frame();
    cnt = 0;
    cif.cmd_ch = 3'd2;
    cif.cmd_us = 15'd140;
    cif.cmd_valid = 1'b1;
    check("coll_rdy_fs", int'(cif.cmd_ready), 0);
    step();
    if (servo_out[2]) cnt++;
    check("coll_rdy_next", int'(cif.cmd_ready), 1);
    check("coll_busy_pre", int'(busy[2]), 0);
    step();
    if (servo_out[2]) cnt++;
    cif.cmd_valid = 1'b0;
    step();
    if (servo_out[2]) cnt++;
    check("coll_busy_post", int'(busy[2]), 1);
    for (int s = 4; s <= FCYC; s++) begin
      step();
      if (servo_out[2]) cnt++;
    end
    check("coll_old_w", cnt, 150 * TPU);
    check("coll_fs", int'(frame_start), 1);
    model[2] = 140;
    check_frame("coll_new");

    // enable dropped mid-pulse, restored mid-frame
    measure(50, 5'b10111, w, b1, b2, fs);
    check("en_a_w3", w[3], model[3] * TPU);
    check("en_a_w2", w[2], model[2] * TPU);
    measure(50, 5'b11111, w, b1, b2, fs);
    check("en_b_w3", w[3], 0);
    check("en_b_w4", w[4], model[4] * TPU);
    check_frame("en_c");

    // reset asserted mid-pulse
    for (int s = 0; s < 50; s++) step();
    check("rst_mid_pre", int'(servo_out), 5'h1F);
    do_reset("rst1");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
